// File: rtl/byte_stripe_ctrl_if.sv
// rtl/byte_stripe_ctrl_if.sv - byte stream in, per-lane holding registers out, status
// master drives the byte stream and lane_ready; slave is the striper.
interface byte_stripe_ctrl_if #(
  parameter int NUM_LANES = 4
);
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;
  logic [8*NUM_LANES-1:0] lane_data;
  logic [NUM_LANES-1:0]   lane_valid;
  logic [NUM_LANES-1:0]   lane_ready;
  logic [7:0]             frame_cnt;
  logic                   busy;

  modport master (
    output in_data, in_valid, in_last, lane_ready,
    input  in_ready, lane_data, lane_valid, frame_cnt, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, lane_ready,
    output in_ready, lane_data, lane_valid, frame_cnt, busy
  );
endinterface

// File: rtl/byte_stripe_ctrl.sv
// rtl/byte_stripe_ctrl.sv - round-robin byte striper over NUM_LANES lanes
// BYTE_STRIPE_ALIGN_PAD_EN: pad short frames with PAD_BYTE so every frame ends on the last lane.
module byte_stripe_ctrl #(
  parameter int NUM_LANES = 4
`ifdef BYTE_STRIPE_ALIGN_PAD_EN
  , parameter logic [7:0] PAD_BYTE = 8'hF7
`endif
) (
  input  logic              clk,
  input  logic              reset,
  byte_stripe_ctrl_if.slave bus
);
  localparam int PW = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1;
  localparam logic [PW-1:0] LAST_LANE = PW'(NUM_LANES - 1);

`ifdef BYTE_STRIPE_ALIGN_PAD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, STRIPE = 2'd1, PAD = 2'd2} state_e;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, STRIPE = 1'b1} state_e;
`endif

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [7:0]           lane_data_q [NUM_LANES];
  logic [7:0]           lane_data_d [NUM_LANES];
  logic [NUM_LANES-1:0] lane_valid_q, lane_valid_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic                 free;
  logic                 in_ready;
  logic                 accept;
  logic [PW-1:0]        ptr_inc;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    lane_data_d  = lane_data_q;
    // A reload below overrides the drain, so a same-cycle drain+load keeps valid high.
    lane_valid_d = lane_valid_q & ~bus.lane_ready;
    frame_cnt_d  = frame_cnt_q;

    free     = !lane_valid_q[ptr_q] | bus.lane_ready[ptr_q];
    ptr_inc  = (ptr_q == LAST_LANE) ? '0 : ptr_q + 1'b1;
    in_ready = !reset & free;
`ifdef BYTE_STRIPE_ALIGN_PAD_EN
    in_ready = in_ready & (state_q != PAD);
`endif
    accept = bus.in_valid & in_ready;

    if (accept) begin
      lane_data_d[ptr_q]  = bus.in_data;
      lane_valid_d[ptr_q] = 1'b1;
      ptr_d               = ptr_inc;
      if (bus.in_last) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = IDLE;
`ifdef BYTE_STRIPE_ALIGN_PAD_EN
        if (ptr_q != LAST_LANE) state_d = PAD;
`endif
      end else begin
        state_d = STRIPE;
      end
    end
`ifdef BYTE_STRIPE_ALIGN_PAD_EN
    else if ((state_q == PAD) && free) begin
      lane_data_d[ptr_q]  = PAD_BYTE;
      lane_valid_d[ptr_q] = 1'b1;
      ptr_d               = ptr_inc;
      if (ptr_q == LAST_LANE) state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      lane_valid_q <= '0;
      frame_cnt_q  <= '0;
      for (int i = 0; i < NUM_LANES; i++) lane_data_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      lane_valid_q <= lane_valid_d;
      frame_cnt_q  <= frame_cnt_d;
      for (int i = 0; i < NUM_LANES; i++) lane_data_q[i] <= lane_data_d[i];
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign bus.lane_data[8*g +: 8] = lane_data_q[g];
  end

  assign bus.in_ready   = in_ready;
  assign bus.lane_valid = lane_valid_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.busy       = (state_q != IDLE) | (|lane_valid_q);
endmodule

// File: tb/tb_byte_stripe_ctrl.sv
// tb/tb_byte_stripe_ctrl.sv - directed self-checking bench for byte_stripe_ctrl
module tb_byte_stripe_ctrl;
  localparam int NL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  byte_stripe_ctrl_if #(.NUM_LANES(NL)) bus ();
  byte_stripe_ctrl #(.NUM_LANES(NL)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int base;
  int c0;
  int errs;
  int cnt [NL];
  logic [11:0] log_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset)
      for (int i = 0; i < NL; i++)
        if (bus.lane_valid[i] && bus.lane_ready[i])
          log_q.push_back({4'(i), bus.lane_data[8*i +: 8]});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int w = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    #1;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w == 50) check_eq("accept timeout", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (bus.busy && w < 50) begin
      tick();
      w++;
    end
    check_eq("drain idle", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_lane(input int lane, input int from, input int exp_n, input logic [31:0] exp_v);
    int n = 0;
    logic [31:0] v = '0;
    for (int j = from; j < log_q.size(); j++)
      if (int'(log_q[j][11:8]) == lane) begin
        v = {v[23:0], log_q[j][7:0]};
        n++;
      end
    check_eq($sformatf("lane%0d count", lane), n, exp_n);
    check_eq($sformatf("lane%0d bytes", lane), v, exp_v);
  endtask

  initial begin
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.lane_ready = '1;
    tick();
    tick();
    check_eq("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("rst lane_valid", {28'd0, bus.lane_valid}, 32'd0);
    check_eq("rst lane_data", bus.lane_data, 32'd0);
    check_eq("rst frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
    check_eq("rst busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    tick();
    check_eq("post-rst in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Eight-byte frame, all lanes draining every cycle.
    base = log_q.size();
    c0 = cyc;
    send(8'h01, 1'b0);
    check_eq("latency valid", {28'd0, bus.lane_valid}, 32'h1);
    check_eq("latency data", {24'd0, bus.lane_data[7:0]}, 32'h01);
    for (int b = 2; b <= 8; b++) send(8'(b), b == 8);
    check_eq("8 byte cycles", cyc - c0, 32'd8);
    check_eq("frame_cnt 1", {24'd0, bus.frame_cnt}, 32'd1);
    wait_idle();
    for (int l = 0; l < NL; l++) check_lane(l, base, 2, {16'd0, 8'(1 + l), 8'(5 + l)});

    // Five-byte frame then a one-byte frame.
    base = log_q.size();
    for (int b = 0; b < 5; b++) send(8'hA0 + 8'(b), b == 4);
`ifdef BYTE_STRIPE_ALIGN_PAD_EN
    for (int k = 0; k < 3; k++) begin
      check_eq("pad in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    check_eq("after pad in_ready", {31'd0, bus.in_ready}, 32'd1);
    send(8'hB0, 1'b1);
    wait_idle();
    check_lane(0, base, 3, 32'h00A0A4B0);
    for (int l = 1; l < NL; l++) check_lane(l, base, 3, {8'd0, 8'hA0 + 8'(l), 16'hF7F7});
`else
    check_eq("no pad in_ready", {31'd0, bus.in_ready}, 32'd1);
    send(8'hB0, 1'b1);
    wait_idle();
    check_lane(0, base, 2, 32'hA0A4);
    check_lane(1, base, 2, 32'hA1B0);
    check_lane(2, base, 1, 32'hA2);
    check_lane(3, base, 1, 32'hA3);
`endif
    check_eq("frame_cnt 3", {24'd0, bus.frame_cnt}, 32'd3);

    // Lane 2 stalls mid-stream.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    base = log_q.size();
    bus.lane_ready = 4'b1011;
    for (int b = 0; b < 6; b++) send(8'hC0 + 8'(b), 1'b0);
    bus.in_data  = 8'hC6;
    bus.in_valid = 1'b1;
    #1;
    check_eq("stall in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("stall lane2 held", {24'd0, bus.lane_data[23:16]}, 32'hC2);
    check_eq("stall busy", {31'd0, bus.busy}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stall in_ready hold", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.lane_ready = '1;
    send(8'hC6, 1'b0);
    check_eq("drain+reload valid", {31'd0, bus.lane_valid[2]}, 32'd1);
    check_eq("drain+reload data", {24'd0, bus.lane_data[23:16]}, 32'hC6);
    send(8'hC7, 1'b1);
    wait_idle();
    for (int l = 0; l < NL; l++) check_lane(l, base, 2, {16'd0, 8'hC0 + 8'(l), 8'hC4 + 8'(l)});
    check_eq("frame_cnt after stall", {24'd0, bus.frame_cnt}, 32'd1);

    // Reset in the middle of a frame.
    bus.lane_ready = '0;
    send(8'hD0, 1'b0);
    send(8'hD1, 1'b0);
    check_eq("pre-rst valid", {28'd0, bus.lane_valid}, 32'h3);
    reset = 1'b1;
    tick();
    check_eq("midrst lane_valid", {28'd0, bus.lane_valid}, 32'd0);
    check_eq("midrst busy", {31'd0, bus.busy}, 32'd0);
    check_eq("midrst frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
    check_eq("midrst in_ready", {31'd0, bus.in_ready}, 32'd0);
    reset = 1'b0;
    bus.lane_ready = '1;
    tick();
    send(8'hE0, 1'b1);
    check_eq("ptr0 after rst valid", {28'd0, bus.lane_valid}, 32'h1);
    check_eq("ptr0 after rst data", {24'd0, bus.lane_data[7:0]}, 32'hE0);
    wait_idle();

    // 256 single-byte frames: frame counter wrap.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    base = log_q.size();
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 1'b1);
      if (i == 254) check_eq("frame_cnt 255", {24'd0, bus.frame_cnt}, 32'd255);
    end
    check_eq("frame_cnt wrap", {24'd0, bus.frame_cnt}, 32'd0);
    wait_idle();
    errs = 0;
    for (int l = 0; l < NL; l++) cnt[l] = 0;
    for (int j = base; j < log_q.size(); j++) begin
      int l;
      logic [7:0] expd;
      l = int'(log_q[j][11:8]);
`ifdef BYTE_STRIPE_ALIGN_PAD_EN
      expd = (l == 0) ? 8'(cnt[l]) : 8'hF7;
`else
      expd = 8'(4 * cnt[l] + l);
`endif
      if (log_q[j][7:0] != expd) errs++;
      cnt[l]++;
    end
    check_eq("wrap byte order errs", errs, 32'd0);
    for (int l = 0; l < NL; l++)
`ifdef BYTE_STRIPE_ALIGN_PAD_EN
      check_eq($sformatf("wrap lane%0d count", l), cnt[l], 32'd256);
`else
      check_eq($sformatf("wrap lane%0d count", l), cnt[l], 32'd64);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
